spi_cmd_decoder: RTL

Byte-level command parser that sits directly downstream of the SPI byte deserializer. It consumes the 8-bit parallel byte plus byte-ready flag and assembles framed register commands: a header byte, a data word for writes, and an XOR checksum. It issues single-cycle write strobes and read requests to the on-chip register bank, and presents the returned read word for the transmit path.

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_cmd_decoder_byte_edge.sv | 29 ++
 rtl/spi_cmd_decoder.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared encodings and default widths for the SPI command
//                decoder slice.
//  Revision    : 1.0  initial release
// ============================================================================
package spi_pkg;

    localparam int ADDR_W     = 7;
    localparam int DATA_BYTES = 2;
    localparam int HDR_WR_BIT = 7;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DATA  = 3'd1,
        CHK   = 3'd2,
        RDREQ = 3'd3,
        RDCAP = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_cmd_decoder_byte_edge.sv
`default_nettype none
// ============================================================================
//  Module      : spi_byte_edge
//  Description : One-cycle byte accept pulse on the rising edge of byte_flg,
//                suppressed while the frame is inactive.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_byte_edge (
    input  logic clk,
    input  logic rst,
    input  logic byte_flg,
    input  logic frame,
    output logic accept
);

    logic r_flg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flg <= 1'b0;
        end else begin
            r_flg <= byte_flg;
        end
    end

    assign accept = byte_flg & ~r_flg & frame;

endmodule
`default_nettype wire

// File: rtl/spi_cmd_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : spi_cmd_decoder
//  Description : Assembles framed header/data/checksum commands from SPI bytes
//                and issues register write strobes and read requests.
//  Revision    : 1.0  initial release
// ============================================================================
module spi_cmd_decoder
    import spi_pkg::*;
#(
    parameter  int ADDR_W     = spi_pkg::ADDR_W,
    parameter  int DATA_BYTES = spi_pkg::DATA_BYTES,
    localparam int DATA_W     = 8 * DATA_BYTES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        din,
    input  logic              byte_flg,
    input  logic              frame,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_vld,
    output logic              err
);

    localparam logic [2:0] c_LAST_CNT = 3'(DATA_BYTES - 1);

    logic              w_acc;
    state_t            r_state, w_state_nxt;
    logic [2:0]        r_cnt, w_cnt_nxt;
    logic [7:0]        r_chk, w_chk_nxt;
    logic              w_wr_nxt, w_rd_nxt, w_vld_nxt, w_err_nxt;
    logic              w_addr_ld, w_data_ld, w_rdata_ld;
    logic [DATA_W-1:0] w_wdata_shift;

    spi_byte_edge u_byte_edge (
        .clk      (clk),
        .rst      (rst),
        .byte_flg (byte_flg),
        .frame    (frame),
        .accept   (w_acc)
    );

    generate
        if (DATA_BYTES == 1) begin : g_shift_single
            assign w_wdata_shift = din;
        end else begin : g_shift_multi
            assign w_wdata_shift = {wdata[DATA_W-9:0], din};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
            r_chk   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_chk   <= w_chk_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_chk_nxt   = r_chk;
        w_wr_nxt    = 1'b0;
        w_rd_nxt    = 1'b0;
        w_vld_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        w_addr_ld   = 1'b0;
        w_data_ld   = 1'b0;
        w_rdata_ld  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_acc) begin
                    w_addr_ld = 1'b1;
                    w_chk_nxt = din;
                    if (din[HDR_WR_BIT]) begin
                        w_state_nxt = DATA;
                        w_cnt_nxt   = 3'd0;
                    end else begin
                        w_state_nxt = RDREQ;
                        w_rd_nxt    = 1'b1;
                    end
                end
            end
            DATA: begin
                if (!frame) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_acc) begin
                    w_data_ld = 1'b1;
                    w_chk_nxt = r_chk ^ din;
                    if (r_cnt == c_LAST_CNT) begin
                        w_state_nxt = CHK;
                    end else begin
                        w_cnt_nxt = r_cnt + 3'd1;
                    end
                end
            end
            CHK: begin
                // frame low also masks the accept pulse, so an abort beats a late checksum byte
                if (!frame) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = IDLE;
                end else if (w_acc) begin
                    w_wr_nxt    = (din == r_chk);
                    w_err_nxt   = (din != r_chk);
                    w_state_nxt = IDLE;
                end
            end
            RDREQ: begin
                // rd_en is visible this cycle; the bank's word is captured on the closing edge
                w_rdata_ld  = 1'b1;
                w_vld_nxt   = 1'b1;
                w_state_nxt = RDCAP;
            end
            RDCAP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (w_state_nxt == IDLE) begin
            w_chk_nxt = 8'd0;
            w_cnt_nxt = 3'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en     <= 1'b0;
            rd_en     <= 1'b0;
            rdata_vld <= 1'b0;
            err       <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            rdata     <= '0;
        end else begin
            wr_en     <= w_wr_nxt;
            rd_en     <= w_rd_nxt;
            rdata_vld <= w_vld_nxt;
            err       <= w_err_nxt;
            if (w_addr_ld) begin
                addr <= din[ADDR_W-1:0];
            end
            if (w_data_ld) begin
                wdata <= w_wdata_shift;
            end
            if (w_rdata_ld) begin
                rdata <= rd_data;
            end
        end
    end

endmodule
`default_nettype wire
